// File: rtl/matrix_result_serializer_if.sv
// Handshake bundle between a packed-matrix producer, the serializer and an
// element-stream sink. The master side is the serializer itself.
interface matrix_result_serializer_if #(
   parameter int ELEM_W = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [4*ELEM_W-1:0]   in_matrix;
   logic                  in_colmajor;
   logic                  out_valid;
   logic                  out_ready;
   logic [ELEM_W-1:0]     out_elem;
   logic                  out_row;
   logic                  out_col;
   logic                  out_first;
   logic                  out_last;

   modport master (
      input  in_valid, in_matrix, in_colmajor, out_ready,
      output in_ready, out_valid, out_elem, out_row, out_col, out_first, out_last
   );

   modport slave (
      output in_valid, in_matrix, in_colmajor, out_ready,
      input  in_ready, out_valid, out_elem, out_row, out_col, out_first, out_last
   );
endinterface

// File: rtl/matrix_result_serializer.sv
// Serializes packed 2x2 matrices {m11,m12,m21,m22} into a tagged element stream,
// with a one-deep pending slot so consecutive matrices stream without bubbles.
module matrix_result_serializer #(
   parameter int ELEM_W = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   matrix_result_serializer_if.master  bus,
   output logic                        busy,
   output logic [7:0]                  mat_count
);
   localparam int MAT_W = 4 * ELEM_W;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t             state_reg, state_next;
   logic [MAT_W-1:0]   act_matrix_reg, act_matrix_next;
   logic               act_colmajor_reg, act_colmajor_next;
   logic [1:0]         act_index_reg, act_index_next;
   logic [MAT_W-1:0]   pend_matrix_reg, pend_matrix_next;
   logic               pend_colmajor_reg, pend_colmajor_next;
   logic               pend_valid_reg, pend_valid_next;
   logic [7:0]         mat_count_reg, mat_count_next;

   logic               sending;
   logic               accept;
   logic               elem_hs;
   logic               last_hs;
   logic               cur_row;
   logic               cur_col;
   logic [ELEM_W-1:0]  elems [4];

   // elems[{row,col}] picks the field for that position; (0,0) sits in the MSBs.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_field
         assign elems[gi] = act_matrix_reg[(3-gi)*ELEM_W +: ELEM_W];
      end
   endgenerate

   assign sending = (state_reg == SEND);
   assign accept  = bus.in_valid & ~pend_valid_reg;
   assign elem_hs = sending & bus.out_ready;
   assign last_hs = elem_hs & (act_index_reg == 2'd3);

   // Column-major order is row-major with the roles of the index bits swapped.
   assign cur_row = act_colmajor_reg ? act_index_reg[0] : act_index_reg[1];
   assign cur_col = act_colmajor_reg ? act_index_reg[1] : act_index_reg[0];

   assign bus.in_ready  = ~pend_valid_reg;
   assign bus.out_valid = sending;
   assign bus.out_elem  = sending ? elems[{cur_row, cur_col}] : '0;
   assign bus.out_row   = sending & cur_row;
   assign bus.out_col   = sending & cur_col;
   assign bus.out_first = sending & (act_index_reg == 2'd0);
   assign bus.out_last  = sending & (act_index_reg == 2'd3);
   assign busy          = sending | pend_valid_reg;
   assign mat_count     = mat_count_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = SEND;
         SEND: if (last_hs && !pend_valid_reg && !accept) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      act_matrix_next    = act_matrix_reg;
      act_colmajor_next  = act_colmajor_reg;
      act_index_next     = act_index_reg;
      pend_matrix_next   = pend_matrix_reg;
      pend_colmajor_next = pend_colmajor_reg;
      pend_valid_next    = pend_valid_reg;
      mat_count_next     = mat_count_reg;

      if (elem_hs && !last_hs) begin
         act_index_next = act_index_reg + 2'd1;
      end

      if (last_hs) begin
         mat_count_next = mat_count_reg + 8'd1;
         if (pend_valid_reg) begin
            act_matrix_next   = pend_matrix_reg;
            act_colmajor_next = pend_colmajor_reg;
            act_index_next    = 2'd0;
            pend_valid_next   = 1'b0;
         end
      end

      // accept implies the pending slot was empty, so it never races the
      // pending-to-active move above.
      if (accept) begin
         if (!sending || last_hs) begin
            act_matrix_next   = bus.in_matrix;
            act_colmajor_next = bus.in_colmajor;
            act_index_next    = 2'd0;
         end else begin
            pend_matrix_next   = bus.in_matrix;
            pend_colmajor_next = bus.in_colmajor;
            pend_valid_next    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg         <= IDLE;
         act_matrix_reg    <= '0;
         act_colmajor_reg  <= 1'b0;
         act_index_reg     <= 2'd0;
         pend_matrix_reg   <= '0;
         pend_colmajor_reg <= 1'b0;
         pend_valid_reg    <= 1'b0;
         mat_count_reg     <= 8'd0;
      end else begin
         state_reg         <= state_next;
         act_matrix_reg    <= act_matrix_next;
         act_colmajor_reg  <= act_colmajor_next;
         act_index_reg     <= act_index_next;
         pend_matrix_reg   <= pend_matrix_next;
         pend_colmajor_reg <= pend_colmajor_next;
         pend_valid_reg    <= pend_valid_next;
         mat_count_reg     <= mat_count_next;
      end
   end
endmodule

// File: tb/tb_matrix_result_serializer.sv
// Self-checking bench: directed scenarios plus a randomized run scored against
// a queue-based model of the element stream.
module tb_matrix_result_serializer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       busy;
   logic [7:0] mat_count;

   int checks   = 0;
   int failures = 0;

   matrix_result_serializer_if #(.ELEM_W(4)) bus ();

   matrix_result_serializer #(.ELEM_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .mat_count (mat_count)
   );

   always #5 clk = ~clk;

   // Expected element: value plus row/col/first/last tags.
   typedef struct packed {
      logic [3:0] e;
      logic       r;
      logic       c;
      logic       f;
      logic       l;
   } exp_t;

   // Values observed in the cycle driven by the last step() call.
   logic       s_in_ready, s_busy;
   logic [7:0] s_count;
   logic [8:0] s_vec;   // {out_valid, elem, row, col, first, last}

   function automatic exp_t elem_of(input logic [15:0] m, input logic cm, input int k);
      exp_t x;
      int   r, c;
      r = cm ? (k % 2) : (k / 2);
      c = cm ? (k / 2) : (k % 2);
      x.e = 4'((m >> (4 * (3 - (2 * r + c)))) & 16'hF);
      x.r = 1'(r);
      x.c = 1'(c);
      x.f = (k == 0);
      x.l = (k == 3);
      return x;
   endfunction

   task automatic step(input logic iv, input logic [15:0] m, input logic cm, input logic ordy);
      @(negedge clk);
      bus.in_valid    = iv;
      bus.in_matrix   = m;
      bus.in_colmajor = cm;
      bus.out_ready   = ordy;
      #1;
      s_in_ready = bus.in_ready;
      s_busy     = busy;
      s_count    = mat_count;
      s_vec      = {bus.out_valid, bus.out_elem, bus.out_row, bus.out_col,
                    bus.out_first, bus.out_last};
      @(posedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [20:0] got;
      bus.in_valid = 1'b0; bus.in_matrix = '0; bus.in_colmajor = 1'b0; bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      got = {bus.in_ready, bus.out_valid, bus.out_elem, bus.out_row, bus.out_col,
             bus.out_first, bus.out_last, busy, mat_count};
      checks++;
      if (got !== {1'b1, 1'b0, 4'h0, 4'b0000, 1'b0, 8'd0}) begin
         failures++;
         $display("FAIL reset_state got=%h exp=%h", got, {1'b1, 1'b0, 4'h0, 4'b0000, 1'b0, 8'd0});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_matrix_order(input logic cm);
      exp_t       x;
      logic [7:0] base;
      base = mat_count;
      step(1'b1, 16'h5724, cm, 1'b1);
      checks++;
      if ({s_in_ready, s_vec[8]} !== 2'b10) begin
         failures++;
         $display("FAIL order%0d_accept got=%b exp=10", cm, {s_in_ready, s_vec[8]});
      end
      for (int k = 0; k < 4; k++) begin
         // Flip the order input while the matrix is held: it must have no effect.
         step(1'b0, 16'h0000, ~cm, 1'b1);
         x = elem_of(16'h5724, cm, k);
         checks++;
         if (s_vec !== {1'b1, x}) begin
            failures++;
            $display("FAIL order%0d_elem%0d got=%h exp=%h", cm, k, s_vec, {1'b1, x});
         end
      end
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      checks++;
      if ({s_vec[8], s_count} !== {1'b0, base + 8'd1}) begin
         failures++;
         $display("FAIL order%0d_done got=%h exp=%h", cm, {s_vec[8], s_count}, {1'b0, base + 8'd1});
      end
   endtask

   task automatic test_backpressure();
      exp_t       x;
      logic [7:0] base;
      base = mat_count;
      step(1'b1, 16'h5724, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      x = elem_of(16'h5724, 1'b0, 1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 16'h0000, 1'b1, 1'b0);
         checks++;
         if (s_vec !== {1'b1, x}) begin
            failures++;
            $display("FAIL backpressure_hold%0d got=%h exp=%h", i, s_vec, {1'b1, x});
         end
      end
      for (int k = 1; k < 4; k++) begin
         step(1'b0, 16'h0000, 1'b0, 1'b1);
         x = elem_of(16'h5724, 1'b0, k);
         checks++;
         if (s_vec !== {1'b1, x}) begin
            failures++;
            $display("FAIL backpressure_elem%0d got=%h exp=%h", k, s_vec, {1'b1, x});
         end
      end
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      checks++;
      if ({s_vec[8], s_count} !== {1'b0, base + 8'd1}) begin
         failures++;
         $display("FAIL backpressure_done got=%h exp=%h", {s_vec[8], s_count}, {1'b0, base + 8'd1});
      end
   endtask

   task automatic test_back_to_back();
      exp_t       x;
      logic [7:0] base;
      logic [15:0] mats [2];
      mats[0] = 16'h1234;
      mats[1] = 16'hABCD;
      base = mat_count;
      step(1'b1, mats[0], 1'b0, 1'b1);
      for (int n = 0; n < 8; n++) begin
         step(n == 0, mats[1], 1'b0, 1'b1);
         if (n < 2) begin
            checks++;
            if (s_in_ready !== (n == 0)) begin
               failures++;
               $display("FAIL b2b_in_ready%0d got=%b exp=%b", n, s_in_ready, (n == 0));
            end
         end
         x = elem_of(mats[n / 4], 1'b0, n % 4);
         checks++;
         if (s_vec !== {1'b1, x}) begin
            failures++;
            $display("FAIL b2b_elem%0d got=%h exp=%h", n, s_vec, {1'b1, x});
         end
      end
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      checks++;
      if ({s_vec[8], s_in_ready, s_count} !== {2'b01, base + 8'd2}) begin
         failures++;
         $display("FAIL b2b_done got=%h exp=%h", {s_vec[8], s_in_ready, s_count}, {2'b01, base + 8'd2});
      end
   endtask

   task automatic test_pending_full();
      logic [15:0] mx, my, mz;
      exp_t        expq[$];
      exp_t        got[$];
      logic        z_acc;
      logic        iv;
      mx = 16'($urandom); my = 16'($urandom); mz = 16'($urandom);
      for (int k = 0; k < 4; k++) expq.push_back(elem_of(mx, 1'b0, k));
      for (int k = 0; k < 4; k++) expq.push_back(elem_of(my, 1'b1, k));
      for (int k = 0; k < 4; k++) expq.push_back(elem_of(mz, 1'b0, k));
      step(1'b1, mx, 1'b0, 1'b0);
      step(1'b1, my, 1'b1, 1'b0);
      checks++;
      if (s_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL pend_second_accept got=%b exp=1", s_in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, mz, 1'b0, 1'b0);
         checks++;
         if ({s_in_ready, s_busy} !== 2'b01) begin
            failures++;
            $display("FAIL pend_full%0d got=%b exp=01", i, {s_in_ready, s_busy});
         end
      end
      z_acc = 1'b0;
      for (int cyc = 0; cyc < 40 && got.size() < 12; cyc++) begin
         iv = ~z_acc;
         step(iv, mz, 1'b0, 1'b1);
         if (iv && s_in_ready) z_acc = 1'b1;
         if (s_vec[8]) got.push_back(exp_t'(s_vec[7:0]));
      end
      checks++;
      if ({z_acc, 5'(got.size())} !== {1'b1, 5'd12}) begin
         failures++;
         $display("FAIL pend_drain got=acc%0b n%0d exp=acc1 n12", z_acc, got.size());
      end
      for (int i = 0; i < 12 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== expq[i]) begin
            failures++;
            $display("FAIL pend_elem%0d got=%h exp=%h", i, got[i], expq[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [11:0] got;
      step(1'b1, 16'h5724, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      got = {bus.out_valid, bus.in_ready, busy, bus.out_first, mat_count};
      checks++;
      if (got !== {4'b0100, 8'd0}) begin
         failures++;
         $display("FAIL async_reset got=%h exp=%h", got, {4'b0100, 8'd0});
      end
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 16'h1234, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 16'h0000, 1'b0, 1'b1);
         checks++;
         if (s_vec !== {1'b1, elem_of(16'h1234, 1'b0, k)}) begin
            failures++;
            $display("FAIL async_restart_elem%0d got=%h exp=%h", k, s_vec, {1'b1, elem_of(16'h1234, 1'b0, k)});
         end
      end
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      checks++;
      if (s_count !== 8'd1) begin
         failures++;
         $display("FAIL async_restart_count got=%0d exp=1", s_count);
      end
   endtask

   task automatic test_random();
      exp_t        sb[$];
      logic [7:0]  mcount;
      logic [18:0] exp_vec, got_vec;
      logic        iv, cm, ordy;
      logic [15:0] m;
      exp_t        head;
      pulse_reset();
      mcount = 8'd0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         iv   = ($urandom_range(0, 2) != 0);
         cm   = 1'($urandom);
         ordy = ($urandom_range(0, 3) != 0);
         m    = 16'($urandom);
         head = (sb.size() > 0) ? sb[0] : exp_t'(8'h00);
         // Model: head of queue is the shown element; a second whole matrix
         // beyond the active one means the pending slot is full.
         exp_vec = {(sb.size() <= 4), (sb.size() > 0), head, (sb.size() > 0), mcount};
         step(iv, m, cm, ordy);
         got_vec = {s_in_ready, s_vec, s_busy, s_count};
         checks++;
         if (got_vec !== exp_vec) begin
            failures++;
            $display("FAIL random_cyc%0d got=%h exp=%h", cyc, got_vec, exp_vec);
         end
         if ((sb.size() > 0) && ordy) begin
            if (sb[0].l) mcount = mcount + 8'd1;
            void'(sb.pop_front());
         end
         if (iv && (exp_vec[18] == 1'b1)) begin
            for (int k = 0; k < 4; k++) sb.push_back(elem_of(m, cm, k));
         end
      end
   endtask

   task automatic test_count_wrap();
      int  accepted, emitted, bubbles;
      bit  seen;
      logic iv;
      pulse_reset();
      accepted = 0; emitted = 0; bubbles = 0; seen = 0;
      for (int cyc = 0; cyc < 1200 && emitted < 256; cyc++) begin
         iv = (accepted < 256);
         step(iv, 16'($urandom), 1'($urandom), 1'b1);
         if (iv && s_in_ready) accepted++;
         if (s_vec[8]) begin
            seen = 1;
            if (s_vec[0]) emitted++;
         end else if (seen) begin
            bubbles++;
         end
         if (emitted == 255 && s_vec[8] && s_vec[0]) begin
            #1;
            checks++;
            if (mat_count !== 8'd255) begin
               failures++;
               $display("FAIL wrap_count255 got=%0d exp=255", mat_count);
            end
         end
      end
      #1;
      checks++;
      if ({mat_count, 9'(emitted), 9'(bubbles)} !== {8'd0, 9'd256, 9'd0}) begin
         failures++;
         $display("FAIL wrap_final got=count%0d emitted%0d bubbles%0d exp=count0 emitted256 bubbles0",
                  mat_count, emitted, bubbles);
      end
   endtask

   initial begin
      test_reset();
      test_matrix_order(1'b0);
      test_matrix_order(1'b1);
      test_backpressure();
      test_back_to_back();
      test_pending_full();
      test_async_reset();
      test_random();
      test_count_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
Transmit side for packed 2x2 matrix results (e.g. 16-bit product C, four 4-bit elements). Accepts one packed matrix per valid/ready handshake. Emits its elements one per cycle on a valid/ready element stream, in row-major or column-major order, with row/col/first/last tags. A one-deep pending slot lets back-to-back matrices stream with no bubble cycles.

Parameters:
ELEM_W, 4, width of one matrix element in bits; packed matrix width is 4*ELEM_W.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
in_valid  input  1  packed matrix offered.
in_ready  output  1  serializer can take a matrix this cycle.
in_matrix  input  4*ELEM_W  packed {m11,m12,m21,m22}; m11 in the MSBs, m22 in the LSBs.
in_colmajor  input  1  order select, sampled with in_matrix: 0 = m11,m12,m21,m22; 1 = m11,m21,m12,m22.
out_valid  output  1  element present.
out_ready  input  1  sink accepts element.
out_elem  output  ELEM_W  current element.
out_row  output  1  row index of out_elem (0/1).
out_col  output  1  column index of out_elem (0/1).
out_first  output  1  element is the first of its matrix.
out_last  output  1  element is the last of its matrix.
busy  output  1  active or pending matrix held.
mat_count  output  8  matrices fully emitted, modulo 256.

Behaviour:
- Reset (async, active-high): all state cleared immediately.
  - Reset values: in_ready=1, out_valid=0, out_elem=0, out_row=0, out_col=0, out_first=0, out_last=0, busy=0, mat_count=0.
  - Reset mid-matrix discards active and pending data; no partial completion is counted.
- Storage: ACTIVE register (matrix, order bit, 2-bit index) and PENDING register (matrix, order bit, valid flag).
- in_ready = ~pending_valid. It is a registered condition, independent of in_valid and of the current out_ready.
- Accept = in_valid & in_ready at a rising edge:
  - If ACTIVE is empty, or its last element handshakes on the same edge, the matrix loads directly into ACTIVE with index 0. out_valid=1 in the next cycle (latency 1).
  - Otherwise the matrix loads into PENDING.
- Element handshake = out_valid & out_ready.
  - Non-last element: index increments.
  - Last element (index 3): if PENDING is valid, it moves to ACTIVE (index 0) and PENDING clears. Otherwise ACTIVE empties and out_valid=0 next cycle.
  - A simultaneous accept is placed per the rule above, so two matrices never contend for ACTIVE.
- Stability: while out_valid=1 and out_ready=0, out_elem, out_row, out_col, out_first and out_last are held constant.
- Index to (row,col):
  - Row-major: 0→(0,0), 1→(0,1), 2→(1,0), 3→(1,1).
  - Column-major: 0→(0,0), 1→(1,0), 2→(0,1), 3→(1,1).
  - out_elem is the field for (row,col): (0,0)=bits[4E-1:3E], (0,1)=[3E-1:2E], (1,0)=[2E-1:E], (1,1)=[E-1:0], where E=ELEM_W.
- Tags: out_first = (index==0). out_last = (index==3). Both are valid only when out_valid=1, and are 0 otherwise.
- Order bit: captured per matrix at accept. Changing in_colmajor later never affects a matrix already held.
- mat_count: increments on each last-element handshake, wrapping 255→0.
- busy = ACTIVE occupied | pending_valid.
- Throughput: with out_ready held high and in_valid continuous, one element per cycle and one matrix accepted every 4 cycles, with no idle cycles after the first.
- FSM: IDLE (ACTIVE empty) → SEND on accept. SEND stays in SEND on a last-element handshake when PENDING is valid or a matrix is accepted that cycle. SEND → IDLE otherwise. No other states.

Test Plan:
- Row-major basic: reset; in_matrix=16'h5724, in_colmajor=0, out_ready=1 → out_elem 5,7,2,4 on 4 consecutive cycles starting 1 cycle after accept; (row,col)=(0,0),(0,1),(1,0),(1,1); first on 5, last on 4; mat_count=1.
- Column-major: in_matrix=16'h5724, in_colmajor=1 → 5,2,7,4; (row,col)=(0,0),(1,0),(0,1),(1,1).
- Backpressure: out_ready low for 3 cycles while element 7 is shown → out_elem=7, out_row=0, out_col=1 held; all tags unchanged; no element lost or duplicated.
- Back-to-back with pending: send 16'h1234 then 16'hABCD, out_ready=1 → in_ready drops after the second accept; stream is 1,2,3,4,A,B,C,D in 8 consecutive cycles; mat_count=2.
- Pending full: out_ready=0, offer three matrices → first two accepted, in_ready=0, third held off until element handshakes resume.
- Async reset mid-matrix: rst pulse after 2 elements of 16'h5724 → out_valid=0 and in_ready=1 immediately; mat_count=0; the next matrix starts from its element (0,0).
- Counter wrap: 256 matrices emitted → mat_count returns to 0.
